pitch_to_period_bank: RTL and testbench

- Multi-channel successor to the single-voice pitch-to-period converter.
- Converts NUM_CH pitch codes (e.g. per-voice pitch pots or modulation values) to sample periods in clock cycles per sample.
- Uses a time-multiplexed, round-robin datapath: a 17-entry mantissa table plus linear interpolation, then a right shift by the octave number.
- Sits between the ADC/control-value registers and the per-voice sample-rate counters. It reports each period change with an update strobe.

---
 rtl/pitch_bank_pkg.sv | 32 +++
 rtl/pitch_mantissa_rom.sv | 31 +++
 rtl/pitch_to_period_bank.sv | 181 ++++++++++++++++++
 tb/tb_pitch_to_period_bank.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pitch_bank_pkg.sv
// Shared types and elaboration-time helpers for the pitch-to-period bank.
// The mantissa helper runs only on constants; it is never evaluated in hardware.
package pitch_bank_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOOKUP,
        ST_MUL,
        ST_WRITE
    } state_e;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // One octave of periods: entry k is BASE * 2^(-k/segments), rounded to nearest.
    // The last entry is pinned to exactly half the base so octaves join seamlessly.
    function automatic int unsigned mantissa_entry(input int unsigned base,
                                                   input int unsigned lut_bits,
                                                   input int unsigned k);
        real seg;
        real v;
        if (k == (32'd1 << lut_bits)) begin
            return base / 2;
        end
        seg = real'(k) / real'(32'd1 << lut_bits);
        v   = real'(base) * (2.0 ** (-seg));
        return $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/pitch_mantissa_rom.sv
// Constant mantissa table for one octave with two combinational read ports.
// Port b reads the entry after port a, giving both interpolation endpoints at once.
module pitch_mantissa_rom
    import pitch_bank_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = 9088,
    parameter int unsigned LUT_BITS    = 4,
    parameter int unsigned PERIOD_W    = 14
) (
    input  logic [LUT_BITS-1:0] idx_i,
    output logic [PERIOD_W-1:0] a_o,
    output logic [PERIOD_W-1:0] b_o
);

    localparam int unsigned ENTRIES = (32'd1 << LUT_BITS) + 32'd1;

    logic [PERIOD_W-1:0] table_w [ENTRIES];
    logic [LUT_BITS:0]   idx_cur;
    logic [LUT_BITS:0]   idx_next;

    for (genvar k = 0; k < ENTRIES; k++) begin : g_tab
        localparam int unsigned VAL = mantissa_entry(BASE_PERIOD, LUT_BITS, k);
        assign table_w[k] = VAL[PERIOD_W-1:0];
    end

    assign idx_cur  = {1'b0, idx_i};
    assign idx_next = idx_cur + 1'b1;
    assign a_o      = table_w[idx_cur];
    assign b_o      = table_w[idx_next];

endmodule

// File: rtl/pitch_to_period_bank.sv
// Round-robin converter of NUM_CH pitch codes into sample periods.
// One shared table/interpolate/shift datapath visits each channel in four cycles.
module pitch_to_period_bank
    import pitch_bank_pkg::*;
#(
    parameter int unsigned NUM_CH       = 8,
    parameter int unsigned PITCH_W      = 10,
    parameter int unsigned FRAC_W       = 8,
    parameter int unsigned LUT_BITS     = 4,
    parameter int unsigned PERIOD_W     = 14,
    parameter int unsigned BASE_PERIOD  = 9088,
    parameter int unsigned MIN_PERIOD   = 64,
    parameter int unsigned RESET_PERIOD = 2272,
    localparam int unsigned CH_W        = ch_width(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_CH*PITCH_W-1:0]    pitch_in,
    output logic [NUM_CH*PERIOD_W-1:0]   period_out,
    output logic                         upd_valid,
    output logic [CH_W-1:0]              upd_ch,
    output logic [PERIOD_W-1:0]          upd_period,
    output logic                         sweep_done
);

    localparam int unsigned OCT_W  = PITCH_W - FRAC_W;
    localparam int unsigned REM_W  = FRAC_W - LUT_BITS;
    localparam int unsigned REM_WE = (REM_W == 0) ? 1 : REM_W;
    localparam int unsigned PROD_W = PERIOD_W + FRAC_W;

    localparam logic [FRAC_W-1:0]   REM_MASK = FRAC_W'((32'd1 << REM_W) - 32'd1);
    localparam logic [CH_W-1:0]     CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [PERIOD_W-1:0] MIN_V    = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] RESET_V  = PERIOD_W'(RESET_PERIOD);

    function automatic logic [PERIOD_W-1:0] clamp_min(input logic [PERIOD_W-1:0] v);
        return (v < MIN_V) ? MIN_V : v;
    endfunction

    state_e               state_q, state_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [OCT_W-1:0]     oct_q, oct_d;
    logic [LUT_BITS-1:0]  idx_q, idx_d;
    logic [REM_WE-1:0]    rem_q, rem_d;
    logic [PERIOD_W-1:0]  a_q, a_d;
    logic [PERIOD_W-1:0]  b_q, b_d;
    logic [PERIOD_W-1:0]  interp_q, interp_d;
    logic                 upd_valid_q, upd_valid_d;
    logic [CH_W-1:0]      upd_ch_q, upd_ch_d;
    logic [PERIOD_W-1:0]  upd_period_q, upd_period_d;
    logic                 sweep_done_q, sweep_done_d;
    logic [PERIOD_W-1:0]  period_q [NUM_CH];
    logic                 lane_we;

    logic [PITCH_W-1:0]   pitch_arr [NUM_CH];
    logic [PITCH_W-1:0]   pitch_sel;
    logic [FRAC_W-1:0]    frac;
    logic [PERIOD_W-1:0]  rom_a, rom_b;
    logic [PERIOD_W-1:0]  seg_diff;
    logic [PROD_W-1:0]    prod;
    logic [PERIOD_W-1:0]  mant;
    logic [PERIOD_W-1:0]  shifted;
    logic [PERIOD_W-1:0]  q_clamped;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        assign pitch_arr[c]                          = pitch_in[c*PITCH_W +: PITCH_W];
        assign period_out[c*PERIOD_W +: PERIOD_W]    = period_q[c];
    end

    pitch_mantissa_rom #(
        .BASE_PERIOD (BASE_PERIOD),
        .LUT_BITS    (LUT_BITS),
        .PERIOD_W    (PERIOD_W)
    ) u_rom (
        .idx_i (idx_q),
        .a_o   (rom_a),
        .b_o   (rom_b)
    );

    assign pitch_sel = pitch_arr[ch_q];
    assign frac      = pitch_sel[FRAC_W-1:0];

    // Product is wide enough that no bits are lost before the segment shift.
    assign seg_diff  = a_q - b_q;
    assign prod      = PROD_W'(seg_diff) * PROD_W'(rem_q);
    assign mant      = a_q - interp_q;
    assign shifted   = mant >> oct_q;
    assign q_clamped = clamp_min(shifted);

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        oct_d        = oct_q;
        idx_d        = idx_q;
        rem_d        = rem_q;
        a_d          = a_q;
        b_d          = b_q;
        interp_d     = interp_q;
        upd_valid_d  = 1'b0;
        upd_ch_d     = upd_ch_q;
        upd_period_d = upd_period_q;
        sweep_done_d = 1'b0;
        lane_we      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                oct_d   = pitch_sel[PITCH_W-1:FRAC_W];
                idx_d   = frac[FRAC_W-1 -: LUT_BITS];
                rem_d   = REM_WE'(frac & REM_MASK);
                state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                a_d     = rom_a;
                b_d     = rom_b;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                interp_d = PERIOD_W'(prod >> REM_W);
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                // Only real changes are written and announced downstream.
                if (q_clamped != period_q[ch_q]) begin
                    lane_we      = 1'b1;
                    upd_valid_d  = 1'b1;
                    upd_ch_d     = ch_q;
                    upd_period_d = q_clamped;
                end
                sweep_done_d = (ch_q == CH_LAST);
                ch_d         = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                state_d      = en ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            oct_q        <= '0;
            idx_q        <= '0;
            rem_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            interp_q     <= '0;
            upd_valid_q  <= 1'b0;
            upd_ch_q     <= '0;
            upd_period_q <= '0;
            sweep_done_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                period_q[c] <= RESET_V;
            end
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            oct_q        <= oct_d;
            idx_q        <= idx_d;
            rem_q        <= rem_d;
            a_q          <= a_d;
            b_q          <= b_d;
            interp_q     <= interp_d;
            upd_valid_q  <= upd_valid_d;
            upd_ch_q     <= upd_ch_d;
            upd_period_q <= upd_period_d;
            sweep_done_q <= sweep_done_d;
            if (lane_we) begin
                period_q[ch_q] <= q_clamped;
            end
        end
    end

    assign upd_valid  = upd_valid_q;
    assign upd_ch     = upd_ch_q;
    assign upd_period = upd_period_q;
    assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_pitch_to_period_bank.sv
// Scoreboard bench for pitch_to_period_bank against an arithmetic reference model.
module tb_pitch_to_period_bank;

    localparam int NUM_CH   = 8;
    localparam int PITCH_W  = 10;
    localparam int PERIOD_W = 14;
    localparam int BASE     = 9088;
    localparam int MINP     = 64;
    localparam int RSTP     = 2272;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        en;
    logic [NUM_CH*PITCH_W-1:0]   pitch_in;
    logic [NUM_CH*PERIOD_W-1:0]  period_out;
    logic                        upd_valid;
    logic [2:0]                  upd_ch;
    logic [PERIOD_W-1:0]         upd_period;
    logic                        sweep_done;

    logic                        en2;
    logic [2*PITCH_W-1:0]        pitch2;
    logic [2*PERIOD_W-1:0]       period2;
    logic                        upd_valid2;
    logic [0:0]                  upd_ch2;
    logic [PERIOD_W-1:0]         upd_period2;
    logic                        sweep_done2;

    always #5 clk = ~clk;

    pitch_to_period_bank dut (
        .clk(clk), .rst(rst), .en(en), .pitch_in(pitch_in), .period_out(period_out),
        .upd_valid(upd_valid), .upd_ch(upd_ch), .upd_period(upd_period), .sweep_done(sweep_done)
    );

    pitch_to_period_bank #(.NUM_CH(2), .MIN_PERIOD(1000)) dut_min (
        .clk(clk), .rst(rst), .en(en2), .pitch_in(pitch2), .period_out(period2),
        .upd_valid(upd_valid2), .upd_ch(upd_ch2), .upd_period(upd_period2), .sweep_done(sweep_done2)
    );

    typedef struct {
        int ch;
        int per;
    } upd_t;

    upd_t sbq[$];
    int   mt[17];
    int   lane_m[NUM_CH];
    int   pit[NUM_CH];
    int   n_tests = 0;
    int   n_fail = 0;
    int   sweeps_seen = 0;
    int   upd_seen = 0;
    int   sweeps_exp = 0;

    // Reference: octave/fraction split, table lookup, linear interpolation, octave shift, floor clamp.
    function automatic int ref_period(int p, int minp);
        int oct, frac, idx, rem, a, b, d, q;
        oct  = p / 256;
        frac = p % 256;
        idx  = frac / 16;
        rem  = frac % 16;
        a    = mt[idx];
        b    = mt[idx+1];
        d    = ((a - b) * rem) / 16;
        q    = (a - d) / (1 << oct);
        return (q < minp) ? minp : q;
    endfunction

    function automatic int lane_out(int c);
        return int'(period_out[c*PERIOD_W +: PERIOD_W]);
    endfunction

    function automatic void push_exp(int c, int v);
        upd_t e;
        e.ch  = c;
        e.per = v;
        sbq.push_back(e);
        lane_m[c] = v;
    endfunction

    function automatic void push_sweep();
        for (int c = 0; c < NUM_CH; c++) begin
            int v;
            v = ref_period(pit[c], MINP);
            if (v != lane_m[c]) push_exp(c, v);
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic set_pitch(input int c, input int p);
        pit[c] = p;
        pitch_in[c*PITCH_W +: PITCH_W] = PITCH_W'(p);
    endtask

    // Run n channel conversions starting from IDLE, dropping en so the FSM idles afterwards.
    task automatic run_channels(input int n);
        @(posedge clk);
        #1 en = 1'b1;
        repeat (4*n - 1) @(posedge clk);
        #1 en = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Full sweep from IDLE; sweep_done must appear 4*NUM_CH cycles after en is first sampled.
    task automatic run_sweep_timed(input string name);
        int k;
        bit found;
        k = 0;
        found = 1'b0;
        @(posedge clk);
        #1 en = 1'b1;
        @(posedge clk);
        while (k < 4*NUM_CH + 20 && !found) begin
            @(posedge clk);
            k++;
            #1;
            if (k == 4*NUM_CH - 2) en = 1'b0;
            if (sweep_done) found = 1'b1;
        end
        en = 1'b0;
        sweeps_exp++;
        check({name, "_sweep_latency"}, found ? k : -1, 4*NUM_CH);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_pending"}, sbq.size(), 0);
        check({name, "_sweep_count"}, sweeps_seen, sweeps_exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (upd_valid) begin
                upd_seen++;
                n_tests++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL upd_unexpected: ch=%0d period=%0d, required no update", upd_ch, upd_period);
                end else begin
                    upd_t e;
                    e = sbq.pop_front();
                    if (int'(upd_ch) != e.ch || int'(upd_period) != e.per || lane_out(int'(upd_ch)) != e.per) begin
                        n_fail++;
                        $display("FAIL upd: ch=%0d period=%0d lane=%0d, required ch=%0d period=%0d",
                                 upd_ch, upd_period, lane_out(int'(upd_ch)), e.ch, e.per);
                    end
                end
            end
            if (sweep_done) sweeps_seen++;
        end
    end

    initial begin
        int base_upd;
        int remaining;
        int k;
        bit found;

        for (int i = 0; i <= 16; i++) begin
            mt[i] = (i == 16) ? BASE / 2 : $rtoi(real'(BASE) * (2.0 ** (-real'(i) / 16.0)) + 0.5);
        end
        rst = 1'b1;
        en = 1'b0;
        en2 = 1'b0;
        pitch_in = '0;
        pitch2 = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pit[c] = 0;
            lane_m[c] = RSTP;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, before en
        for (int c = 0; c < NUM_CH; c++) check($sformatf("reset_lane%0d", c), lane_out(c), RSTP);
        check("reset_upd_valid", int'(upd_valid), 0);
        check("reset_upd_ch", int'(upd_ch), 0);
        check("reset_upd_period", int'(upd_period), 0);
        check("reset_sweep_done", int'(sweep_done), 0);

        // Directed first sweep with known periods
        set_pitch(0, 0);
        set_pitch(1, 256);
        set_pitch(2, 768);
        set_pitch(3, 128);
        for (int c = 4; c < NUM_CH; c++) set_pitch(c, 0);
        push_exp(0, 9088);
        push_exp(1, 4544);
        push_exp(2, 1136);
        push_exp(3, 6426);
        for (int c = 4; c < NUM_CH; c++) push_exp(c, 9088);
        run_sweep_timed("directed");

        // Interpolated top-of-range pitch
        set_pitch(0, 1023);
        push_exp(0, 569);
        run_sweep_timed("pitch1023");

        // Unchanged pitches: no strobes
        base_upd = upd_seen;
        run_sweep_timed("steady");
        check("steady_no_upd", upd_seen - base_upd, 0);

        // Pause during ch2 MUL, resume at ch3
        set_pitch(2, 500);
        set_pitch(3, 900);
        set_pitch(4, 300);
        push_sweep();
        remaining = 0;
        foreach (sbq[i]) if (sbq[i].ch >= 3) remaining++;
        run_channels(3);
        check("pause_remaining", sbq.size(), remaining);
        base_upd = upd_seen;
        repeat (10) @(posedge clk);
        #1;
        check("pause_idle_quiet", upd_seen - base_upd, 0);
        run_channels(NUM_CH - 3);
        sweeps_exp++;
        check("resume_pending", sbq.size(), 0);
        check("resume_sweep_count", sweeps_seen, sweeps_exp);

        // Reset in the middle of a conversion
        set_pitch(0, 700);
        set_pitch(5, 100);
        base_upd = upd_seen;
        @(posedge clk);
        #1 en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) lane_m[c] = RSTP;
        for (int c = 0; c < NUM_CH; c++) check($sformatf("midrst_lane%0d", c), lane_out(c), RSTP);
        check("midrst_no_upd", upd_seen - base_upd, 0);
        push_sweep();
        run_sweep_timed("after_rst");

        // Randomized sweeps
        for (int it = 0; it < 6; it++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(1, 0) == 1) set_pitch(c, int'($urandom_range(1023, 0)));
            end
            push_sweep();
            run_sweep_timed($sformatf("rand%0d", it));
        end

        // Floor clamp on a second instance with MIN_PERIOD = 1000
        pitch2[PITCH_W-1:0] = 10'd1023;
        @(posedge clk);
        #1 en2 = 1'b1;
        k = 0;
        found = 1'b0;
        while (k < 20 && !found) begin
            @(posedge clk);
            k++;
            #1;
            if (upd_valid2) found = 1'b1;
        end
        check("clamp_strobe_seen", int'(found), 1);
        check("clamp_upd_ch", int'(upd_ch2), 0);
        check("clamp_upd_period", int'(upd_period2), 1000);
        check("clamp_lane0", int'(period2[PERIOD_W-1:0]), 1000);
        en2 = 1'b0;
        repeat (8) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
